// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
//
// Instruction fetch stage. Issues one registered request per instruction word
// on a simple req/ack bus and hands the word to the IF/ID register. Supports
// back-pressure from the pipeline (stall[1]), delayed branch redirection from
// ID (one delay slot), and exception flushes.
//
// State table:
//   state | meaning
//   IDLE  | pc holds the next address; request goes out on the next edge
//   BUSY  | request outstanding at mem_addr; waiting for mem_ack
//   HOLD  | word captured in inst_buf; waiting for IF/ID to accept it
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active high
//   stall[5:0]     in   pipeline stall vector; bit 1 = IF/ID hold, bit 2 = ID hold
//   flush          in   exception flush, fetch restarts at new_pc
//   new_pc[31:0]   in   flush target
//   branch_flag    in   taken branch/jump resolved in ID
//   branch_target  in   branch/jump target
//   mem_req        out  instruction bus request (registered)
//   mem_addr       out  instruction bus address (registered)
//   mem_ack        in   bus read complete; mem_rdata valid in the same cycle
//   mem_rdata      in   instruction word
//   if_pc          out  address of the instruction presented on if_inst
//   if_inst        out  instruction to IF/ID, zero means bubble
//   stallreq       out  combinational stall request to the pipeline control
// ----------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] inst_buf, inst_buf_nxt;
    logic        redir_valid, redir_valid_nxt;
    logic [31:0] redir_pc, redir_pc_nxt;
    logic        mem_req_nxt;
    logic [31:0] mem_addr_nxt;

    logic        advance;
    logic        branch_acc;
    logic [31:0] seq_pc;
    logic [31:0] adv_pc;

    // Only the IF/ID and ID hold bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5:3], stall[0]};

    always_ff @(posedge clk) begin
        state       <= state_nxt;
        pc          <= pc_nxt;
        inst_buf    <= inst_buf_nxt;
        redir_valid <= redir_valid_nxt;
        redir_pc    <= redir_pc_nxt;
        mem_req     <= mem_req_nxt;
        mem_addr    <= mem_addr_nxt;
    end

    always_comb begin
        branch_acc = branch_flag && !stall[2];
        seq_pc     = pc + 32'd4;
        // A branch accepted in the same cycle the current word retires goes
        // straight into pc; otherwise a parked redirect wins over pc+4.
        adv_pc     = branch_acc  ? branch_target :
                     redir_valid ? redir_pc      : seq_pc;

        state_nxt       = state;
        pc_nxt          = pc;
        inst_buf_nxt    = inst_buf;
        redir_valid_nxt = redir_valid;
        redir_pc_nxt    = redir_pc;
        mem_req_nxt     = mem_req;
        mem_addr_nxt    = mem_addr;
        advance         = 1'b0;

        stallreq = 1'b0;
        if_inst  = 32'h0;
        if_pc    = pc;

        if (rst) begin
            state_nxt       = IDLE;
            pc_nxt          = RESET_PC;
            inst_buf_nxt    = 32'h0;
            redir_valid_nxt = 1'b0;
            redir_pc_nxt    = 32'h0;
            mem_req_nxt     = 1'b0;
            mem_addr_nxt    = 32'h0;
        end else if (flush) begin
            // Aborts any outstanding bus cycle; a late ack lands in IDLE and
            // is ignored there.
            state_nxt       = IDLE;
            pc_nxt          = new_pc;
            redir_valid_nxt = 1'b0;
            mem_req_nxt     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stallreq     = 1'b1;
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = pc;
                    state_nxt    = BUSY;
                end
                BUSY: begin
                    if (mem_ack) begin
                        // Bypass the returning word so a non-stalled pipe
                        // loses no cycle.
                        if_inst     = mem_rdata;
                        mem_req_nxt = 1'b0;
                        if (stall[1]) begin
                            inst_buf_nxt = mem_rdata;
                            state_nxt    = HOLD;
                        end else begin
                            advance   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        stallreq = 1'b1;
                    end
                end
                HOLD: begin
                    if_inst = inst_buf;
                    if (!stall[1]) begin
                        advance   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (advance) begin
                pc_nxt          = adv_pc;
                redir_valid_nxt = 1'b0;
            end else if (branch_acc) begin
                // The word currently in fetch is the delay slot; park the
                // target until it retires.
                redir_valid_nxt = 1'b1;
                redir_pc_nxt    = branch_target;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .stallreq      (stallreq)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        br;
        logic [31:0] bt;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_sreq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic [5:0] st, input logic fl, input logic [31:0] np,
        input logic br, input logic [31:0] bt, input logic ack, input logic [31:0] rd,
        input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
        input logic [31:0] e_inst, input logic e_sreq);
        vec_t v;
        v.rst = r; v.stall = st; v.flush = fl; v.new_pc = np;
        v.br = br; v.bt = bt; v.ack = ack; v.rdata = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc;
        v.e_inst = e_inst; v.e_sreq = e_sreq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] st, input logic fl,
                         input logic [31:0] np, input logic br, input logic [31:0] bt,
                         input logic ack, input logic [31:0] rd);
        rst = r; stall = st; flush = fl; new_pc = np;
        branch_flag = br; branch_target = bt; mem_ack = ack; mem_rdata = rd;
    endtask

    task automatic expect_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic e_sreq);
        chk({tag, " mem_req"},  {31'h0, mem_req},  {31'h0, e_req});
        chk({tag, " mem_addr"}, mem_addr, e_addr);
        chk({tag, " if_pc"},    if_pc,    e_pc);
        chk({tag, " if_inst"},  if_inst,  e_inst);
        chk({tag, " stallreq"}, {31'h0, stallreq}, {31'h0, e_sreq});
    endtask

    localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h2222_0001, A2 = 32'h3333_0002;
    localparam logic [31:0] A3 = 32'h4444_0003, A4 = 32'h5555_0004, A5 = 32'h6666_0005;
    localparam logic [31:0] A6 = 32'h7777_0006, DEAD = 32'hDEAD_BEEF;
    localparam logic [31:0] WRAP = 32'hFFFF_FFFC;
    localparam logic [5:0]  S0 = 6'b000000, S1 = 6'b000010, S2 = 6'b000100, SX = 6'b111001;

    initial begin
        int cycles;

        drive(1'b1, S0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);

        //              rst  stall flush new_pc  br  bt       ack rdata  req addr   pc       inst sreq
        vecs.push_back(mk(1, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h0,   32'h0,   32'h0, 0)); // reset state
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h0,   32'h0,   32'h0, 1)); // IDLE
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   1, A0,    1, 32'h0,   32'h0,   A0,    0)); // ack 0x0
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h0,   32'h4,   32'h0, 1));
        vecs.push_back(mk(0, S1, 0, 32'h0,   0, 32'h0,   1, A1,    1, 32'h4,   32'h4,   A1,    0)); // ack 0x4, held
        vecs.push_back(mk(0, S1, 0, 32'h0,   0, 32'h0,   1, DEAD,  0, 32'h4,   32'h4,   A1,    0)); // HOLD, stray ack
        vecs.push_back(mk(0, S1, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h4,   32'h4,   A1,    0));
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h4,   32'h4,   A1,    0)); // release
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h4,   32'h8,   32'h0, 1));
        vecs.push_back(mk(0, SX, 0, 32'h0,   1, 32'h100, 0, 32'h0, 1, 32'h8,   32'h8,   32'h0, 1)); // branch in BUSY
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   1, A2,    1, 32'h8,   32'h8,   A2,    0)); // delay slot
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h8,   32'h100, 32'h0, 1));
        vecs.push_back(mk(0, S2, 0, 32'h0,   1, 32'h200, 0, 32'h0, 1, 32'h100, 32'h100, 32'h0, 1)); // ID held: ignored
        vecs.push_back(mk(0, S0, 0, 32'h0,   1, 32'h300, 1, A3,    1, 32'h100, 32'h100, A3,    0)); // branch + advance
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h100, 32'h300, 32'h0, 1));
        vecs.push_back(mk(0, S0, 0, 32'h0,   1, 32'h400, 0, 32'h0, 1, 32'h300, 32'h300, 32'h0, 1)); // parked redirect
        vecs.push_back(mk(0, S0, 1, 32'h180, 0, 32'h0,   0, 32'h0, 1, 32'h300, 32'h300, 32'h0, 0)); // flush mid-BUSY
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   1, DEAD,  0, 32'h300, 32'h180, 32'h0, 1)); // late ack
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 1, 32'h180, 32'h180, 32'h0, 1));
        vecs.push_back(mk(0, S1, 0, 32'h0,   0, 32'h0,   1, A4,    1, 32'h180, 32'h180, A4,    0));
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h180, 32'h180, A4,    0));
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h180, 32'h184, 32'h0, 1)); // redirect dropped
        vecs.push_back(mk(0, S1, 0, 32'h0,   0, 32'h0,   1, A5,    1, 32'h184, 32'h184, A5,    0));
        vecs.push_back(mk(0, S1, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h184, 32'h184, A5,    0)); // HOLD
        vecs.push_back(mk(1, S1, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h184, 32'h184, 32'h0, 0)); // rst in HOLD
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h0,   32'h0,   32'h0, 1));
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 1, 32'h0,   32'h0,   32'h0, 1));
        vecs.push_back(mk(0, S0, 1, WRAP,    0, 32'h0,   0, 32'h0, 1, 32'h0,   32'h0,   32'h0, 0));
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h0,   WRAP,    32'h0, 1));
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   1, A6,    1, WRAP,    WRAP,    A6,    0)); // top of memory
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, WRAP,    32'h0,   32'h0, 1)); // wrapped
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 1, 32'h0,   32'h0,   32'h0, 1));
        vecs.push_back(mk(1, S0, 0, 32'h0,   0, 32'h0,   1, DEAD,  1, 32'h0,   32'h0,   32'h0, 0)); // rst mid-BUSY
        vecs.push_back(mk(0, S0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h0,   32'h0,   32'h0, 1)); // ack not taken

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].new_pc,
                  vecs[i].br, vecs[i].bt, vecs[i].ack, vecs[i].rdata);
            #1;
            expect_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                       vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_sreq);
            @(negedge clk);
        end

        // Long wait state: request and address must stay put until ack.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, S0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            #1;
            expect_all($sformatf("wait%0d", k), 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
            @(negedge clk);
        end

        // Capture into HOLD, then flush while still held.
        drive(1'b0, S1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
        #1;
        expect_all("hold_ack", 1'b1, 32'h0, 32'h0, 32'hCAFE_0001, 1'b0);
        @(negedge clk);
        drive(1'b0, S1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        expect_all("hold_flush", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, S0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        expect_all("post_flush", 1'b0, 32'h0, 32'h40, 32'h0, 1'b1);

        cycles = 0;
        while (!mem_req && cycles < 4) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk("req_timeout", {31'h0, mem_req}, 32'h1);
        chk("req_latency", cycles, 1);
        chk("req_addr", mem_addr, 32'h40);

        drive(1'b0, S0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0002);
        #1;
        expect_all("flush_fetch", 1'b1, 32'h40, 32'h40, 32'hCAFE_0002, 1'b0);
        @(negedge clk);
        drive(1'b0, S0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        expect_all("flush_next", 1'b0, 32'h40, 32'h44, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
